// File: rtl/laser_pkg.sv
// Shared types for the laser transmit scheduler: byte type and lane selector.
package laser_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic {
        LANE1 = 1'b0,
        LANE2 = 1'b1
    } lane_t;

endpackage

// File: rtl/laser_tx_fifo.sv
// Byte FIFO between the host and the lane registers; occupancy is tracked by an explicit count.
module laser_tx_fifo
    import laser_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  byte_t                    push_data,
    input  logic                     pop,
    output byte_t                    head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    byte_t           mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers wrap naturally at DEPTH; the count alone tells full from empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/laser_tx_scheduler.sv
// Splits a buffered host byte stream across two laser lanes in strict lane1/lane2 alternation.
// Handshake: a byte transfers on in_valid & in_ready; a lane byte retires on laneX_done while laneX_ready.
module laser_tx_scheduler
    import laser_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic                     flush,
    input  byte_t                    in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output byte_t                    lane1_data,
    output logic                     lane1_ready,
    input  logic                     lane1_done,
    output byte_t                    lane2_data,
    output logic                     lane2_ready,
    input  logic                     lane2_done,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         bytes_sent,
    output logic                     done_err,
    output lane_t                    next_lane_dbg
);

    localparam int CW = $clog2(DEPTH) + 1;

    byte_t             lane_data_q [2];
    byte_t             lane_data_d [2];
    logic [1:0]        lane_ready_q, lane_ready_d;
    lane_t             next_lane_q, next_lane_d;
    logic [CNT_W-1:0]  bytes_sent_q, bytes_sent_d;
    logic              done_err_q, done_err_d;

    logic [1:0]        done;
    logic [1:0]        retire;
    logic [1:0]        lane_free;
    logic              sel;
    logic              load;
    logic              fifo_empty;
    byte_t             fifo_head;

    assign done      = {lane2_done, lane1_done};
    assign retire    = done & lane_ready_q;
    assign lane_free = ~lane_ready_q | done;
    assign sel       = (next_lane_q == LANE2);
    // Only the lane whose turn it is may load; a free other lane does not jump the queue.
    assign load      = en && !fifo_empty && lane_free[sel] && !flush;
    assign in_ready  = (fifo_count < CW'(DEPTH));

    laser_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .push      (in_valid && in_ready),
        .push_data (in_data),
        .pop       (load),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_comb begin
        lane_data_d  = lane_data_q;
        lane_ready_d = lane_ready_q;
        next_lane_d  = next_lane_q;
        bytes_sent_d = bytes_sent_q;
        done_err_d   = done_err_q | (|(done & ~lane_ready_q));
        if (flush) begin
            lane_data_d[0] = '0;
            lane_data_d[1] = '0;
            lane_ready_d   = '0;
            next_lane_d    = LANE1;
        end else begin
            bytes_sent_d = bytes_sent_q + CNT_W'(retire[0]) + CNT_W'(retire[1]);
            lane_ready_d = lane_ready_q & ~retire;
            if (load) begin
                lane_ready_d[sel] = 1'b1;
                lane_data_d[sel]  = fifo_head;
                next_lane_d       = sel ? LANE1 : LANE2;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lane_data_q[0] <= '0;
            lane_data_q[1] <= '0;
            lane_ready_q   <= '0;
            next_lane_q    <= LANE1;
            bytes_sent_q   <= '0;
            done_err_q     <= 1'b0;
        end else begin
            lane_data_q    <= lane_data_d;
            lane_ready_q   <= lane_ready_d;
            next_lane_q    <= next_lane_d;
            bytes_sent_q   <= bytes_sent_d;
            done_err_q     <= done_err_d;
        end
    end

    assign lane1_data    = lane_data_q[0];
    assign lane2_data    = lane_data_q[1];
    assign lane1_ready   = lane_ready_q[0];
    assign lane2_ready   = lane_ready_q[1];
    assign bytes_sent    = bytes_sent_q;
    assign done_err      = done_err_q;
    assign next_lane_dbg = next_lane_q;

endmodule

// File: tb/tb_laser_tx_scheduler.sv
// Self-checking bench for laser_tx_scheduler: reference model plus byte scoreboard.
module tb_laser_tx_scheduler;
    import laser_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clock;
    logic              reset_n;
    logic              en;
    logic              flush;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        lane1_data;
    logic              lane1_ready;
    logic              lane1_done;
    logic [7:0]        lane2_data;
    logic              lane2_ready;
    logic              lane2_done;
    logic [CW-1:0]     fifo_count;
    logic [CNT_W-1:0]  bytes_sent;
    logic              done_err;
    lane_t             next_lane_dbg;

    laser_tx_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .en            (en),
        .flush         (flush),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .lane1_data    (lane1_data),
        .lane1_ready   (lane1_ready),
        .lane1_done    (lane1_done),
        .lane2_data    (lane2_data),
        .lane2_ready   (lane2_ready),
        .lane2_done    (lane2_done),
        .fifo_count    (fifo_count),
        .bytes_sent    (bytes_sent),
        .done_err      (done_err),
        .next_lane_dbg (next_lane_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // scoreboard: bytes accepted but not yet loaded into a lane, in arrival order
    logic [7:0]        exp_q[$];
    logic [1:0]        m_rdy;
    logic [7:0]        m_data [2];
    int                m_next;
    logic [CNT_W-1:0]  m_sent;
    logic              m_err;
    logic              m_valid = 1'b0;

    task automatic tick(input logic v, input logic [7:0] d, input logic [1:0] dn,
                        input logic fl, input logic e, input logic rst_n_in,
                        output logic accepted);
        logic [1:0] ret;
        logic [1:0] free;
        logic       ld;
        logic       psh;
        in_valid   = v;
        in_data    = d;
        lane1_done = dn[0];
        lane2_done = dn[1];
        flush      = fl;
        en         = e;
        reset_n    = rst_n_in;
        if (m_valid) check_eq("in_ready", in_ready, exp_q.size() < DEPTH);
        psh      = v && (exp_q.size() < DEPTH);
        accepted = psh && rst_n_in && !fl;
        if (!rst_n_in) begin
            exp_q.delete();
            m_rdy = '0; m_data[0] = '0; m_data[1] = '0; m_next = 0;
            m_sent = '0; m_err = 1'b0; m_valid = 1'b1;
        end else if (fl) begin
            m_err = m_err | (|(dn & ~m_rdy));
            exp_q.delete();
            m_rdy = '0; m_data[0] = '0; m_data[1] = '0; m_next = 0;
        end else begin
            m_err  = m_err | (|(dn & ~m_rdy));
            ret    = dn & m_rdy;
            free   = ~m_rdy | dn;
            ld     = e && (exp_q.size() > 0) && free[m_next];
            m_sent = m_sent + CNT_W'(ret[0]) + CNT_W'(ret[1]);
            m_rdy  = m_rdy & ~ret;
            if (ld) begin
                m_data[m_next] = exp_q.pop_front();
                m_rdy[m_next]  = 1'b1;
                m_next         = 1 - m_next;
            end
            if (psh) exp_q.push_back(d);
        end
        @(posedge clock);
        #1;
        check_eq("lane1_ready", lane1_ready, m_rdy[0]);
        check_eq("lane2_ready", lane2_ready, m_rdy[1]);
        check_eq("lane1_data",  lane1_data,  m_data[0]);
        check_eq("lane2_data",  lane2_data,  m_data[1]);
        check_eq("fifo_count",  fifo_count,  exp_q.size());
        check_eq("bytes_sent",  bytes_sent,  m_sent);
        check_eq("done_err",    done_err,    m_err);
        check_eq("next_lane",   next_lane_dbg, m_next);
    endtask

    // driver helpers
    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b1, a);
    endtask

    task automatic push(input logic [7:0] d);
        logic a;
        tick(1'b1, d, 2'b00, 1'b0, 1'b1, 1'b1, a);
    endtask

    task automatic drain(input int n);
        logic a;
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, m_rdy, 1'b0, 1'b1, 1'b1, a);
    endtask

    initial begin
        logic             a;
        int               pushed;
        int               pairs;
        logic [CNT_W-1:0] s0;
        logic [1:0]       dn;
        reset_n = 1'b0; en = 1'b0; flush = 1'b0; in_data = '0; in_valid = 1'b0;
        lane1_done = 1'b0; lane2_done = 1'b0;
        for (int i = 0; i < 2; i++) tick(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0, a);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_count", fifo_count, 0);
        check_eq("rst_l1_ready", lane1_ready, 0);
        check_eq("rst_l2_data", lane2_data, 0);

        // 1: two bytes land in lane1 then lane2
        push(8'h08);
        push(8'h17);
        idle(2);
        check_eq("t1_l1_data", lane1_data, 8'h08);
        check_eq("t1_l2_data", lane2_data, 8'h17);
        check_eq("t1_both_ready", {lane2_ready, lane1_ready}, 2'b11);
        check_eq("t1_count", fifo_count, 0);

        // 2: lane2 done alone must not let lane2 jump ahead of lane1
        tick(1'b0, 8'h00, 2'b11, 1'b0, 1'b1, 1'b1, a);
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        idle(2);
        tick(1'b0, 8'h00, 2'b10, 1'b0, 1'b1, 1'b1, a);
        idle(2);
        check_eq("t2_l2_waits", lane2_ready, 0);
        check_eq("t2_count", fifo_count, 2);
        check_eq("t2_err", done_err, 0);
        tick(1'b0, 8'h00, 2'b01, 1'b0, 1'b1, 1'b1, a);
        check_eq("t2_b2b_ready", lane1_ready, 1);
        idle(2);
        check_eq("t2_l1_a2", lane1_data, 8'hA2);
        check_eq("t2_l2_a3", lane2_data, 8'hA3);
        drain(4);

        // 3: overfill, in_ready must drop at DEPTH
        pushed = 0;
        for (int c = 0; c < 40 && pushed < DEPTH + 2; c++) begin
            tick(1'b1, 8'hC0 + 8'(pushed), 2'b00, 1'b0, 1'b1, 1'b1, a);
            if (a) pushed++;
        end
        check_eq("t3_pushed", pushed, DEPTH + 2);
        check_eq("t3_full_count", fifo_count, DEPTH);
        check_eq("t3_in_ready", in_ready, 0);
        idle(3);
        check_eq("t3_still_full", fifo_count, DEPTH);
        drain(60);
        check_eq("t3_drained", fifo_count, 0);

        // 4: random stream with paired dones, en occasionally low
        s0 = bytes_sent;
        pairs = 0;
        for (int c = 0; c < 120; c++) begin
            dn = ((m_rdy == 2'b11) && ($urandom_range(0, 1) == 1)) ? 2'b11 : 2'b00;
            if (dn == 2'b11) pairs++;
            tick(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), dn, 1'b0,
                 ($urandom_range(0, 7) != 0), 1'b1, a);
        end
        check_eq("t4_sent_pairs", bytes_sent - s0, CNT_W'(2 * pairs));
        check_eq("t4_err_clear", done_err, 0);
        drain(60);

        // 5: done on an empty lane sets the sticky error only
        s0 = bytes_sent;
        tick(1'b0, 8'h00, 2'b01, 1'b0, 1'b1, 1'b1, a);
        check_eq("t5_err", done_err, 1);
        check_eq("t5_sent", bytes_sent, s0);
        idle(3);
        check_eq("t5_err_sticky", done_err, 1);

        // 6: flush with done and push keeps counters, clears the rest
        for (int i = 0; i < 6; i++) push(8'h50 + 8'(i));
        idle(1);
        s0 = bytes_sent;
        tick(1'b1, 8'hEE, 2'b11, 1'b1, 1'b1, 1'b1, a);
        check_eq("t6_count", fifo_count, 0);
        check_eq("t6_ready", {lane2_ready, lane1_ready}, 2'b00);
        check_eq("t6_next", next_lane_dbg, LANE1);
        check_eq("t6_sent", bytes_sent, s0);
        check_eq("t6_err_kept", done_err, 1);
        for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
        idle(2);
        tick(1'b1, 8'hEF, 2'b11, 1'b0, 1'b1, 1'b0, a);
        check_eq("t6r_sent", bytes_sent, 0);
        check_eq("t6r_err", done_err, 0);
        check_eq("t6r_count", fifo_count, 0);
        push(8'h71);
        push(8'h72);
        idle(2);
        check_eq("t6r_l1", lane1_data, 8'h71);
        check_eq("t6r_l2", lane2_data, 8'h72);
        drain(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
